// File: rtl/sodor5_lockstep_monitor.sv
// sodor5_lockstep_monitor
//   Observer for the two-copy Sodor 5-stage information-flow harness.
//   After a start pulse it waits WARMUP_CYCLES cycles. It then compares the
//   two copies' load-buffer table and mem-stage PC for up to CHECK_WINDOW
//   cycles. The first divergence is captured: a sticky flag, the cause mask,
//   the armed-cycle index and both LB addresses.
//
//   Optional feature macro: LB_DATA_CHECK_EN
//     defined     -> div_cause[2] (LB data mismatch) is active.
//     not defined -> div_cause[2] is tied 0 and lb_data1/2 are ignored.
//
//   Handshake: start is a single-cycle request with no ready. It is accepted
//   only in IDLE or DONE and silently dropped in WARMUP and ARMED. The result
//   outputs are valid while done=1 and hold until the next accepted start.
//
//   fsm_state exposes the controller state for observation:
//   0=IDLE, 1=WARMUP, 2=ARMED, 3=DONE.
module sodor5_lockstep_monitor #(
  parameter int XLEN          = 32,
  parameter int WARMUP_CYCLES = 6,
  parameter int CHECK_WINDOW  = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             lb_valid1,
  input  logic             lb_valid2,
  input  logic [XLEN-1:0]  lb_addr1,
  input  logic [XLEN-1:0]  lb_addr2,
  input  logic [XLEN-1:0]  lb_data1,
  input  logic [XLEN-1:0]  lb_data2,
  input  logic [XLEN-1:0]  mem_pc1,
  input  logic [XLEN-1:0]  mem_pc2,
  output logic             armed,
  output logic             diverged,
  output logic [3:0]       div_cause,
  output logic [CNT_W-1:0] div_cycle,
  output logic [XLEN-1:0]  snap_addr1,
  output logic [XLEN-1:0]  snap_addr2,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_ARMED  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(CHECK_WINDOW - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       cause;
  logic             mismatch;
  logic             clear_run;
  logic             capture;
  logic             window_end;

`ifndef LB_DATA_CHECK_EN
  // Data ports are not compared in this build; fold them into one ignored net.
  logic unused_data;
  assign unused_data = ^{lb_data1, lb_data2};
`endif

  // Per-cycle divergence cause from the current inputs of both copies.
  always_comb begin
    cause    = 4'b0000;
    cause[0] = lb_valid1 ^ lb_valid2;
    cause[1] = lb_valid1 & lb_valid2 & (lb_addr1 != lb_addr2);
`ifdef LB_DATA_CHECK_EN
    cause[2] = lb_valid1 & lb_valid2 & (lb_data1 != lb_data2);
`else
    cause[2] = 1'b0;
`endif
    cause[3] = (mem_pc1 != mem_pc2);
    mismatch = |cause;
  end

  // Next-state logic plus the strobes that drive the result registers.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clear_run  = 1'b0;
    capture    = 1'b0;
    window_end = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_WARMUP;
          cnt_nxt   = '0;
          clear_run = 1'b1;
        end
      end
      S_WARMUP: begin
        if (cnt == WARM_LAST) begin
          state_nxt = S_ARMED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ARMED: begin
        if (mismatch) begin
          state_nxt = S_DONE;
          capture   = 1'b1;
        end else if (cnt == WIN_LAST) begin
          state_nxt  = S_DONE;
          window_end = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register and shared warm-up/window counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Result registers: cleared by an accepted start, loaded on the first mismatch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      diverged   <= 1'b0;
      div_cause  <= 4'b0000;
      div_cycle  <= '0;
      snap_addr1 <= '0;
      snap_addr2 <= '0;
      done       <= 1'b0;
    end else if (clear_run) begin
      diverged   <= 1'b0;
      div_cause  <= 4'b0000;
      div_cycle  <= '0;
      snap_addr1 <= '0;
      snap_addr2 <= '0;
      done       <= 1'b0;
    end else if (capture) begin
      diverged   <= 1'b1;
      div_cause  <= cause;
      div_cycle  <= cnt;
      snap_addr1 <= lb_addr1;
      snap_addr2 <= lb_addr2;
      done       <= 1'b1;
    end else if (window_end) begin
      done <= 1'b1;
    end
  end

  assign armed     = (state == S_ARMED);
  assign pass      = done & ~diverged;
  assign fsm_state = state;

endmodule

// File: tb/tb_sodor5_lockstep_monitor.sv
// tb_sodor5_lockstep_monitor
//   Directed scenarios followed by randomized runs for sodor5_lockstep_monitor.
//   Expected results come from a run-level reference model. The model counts
//   cycles since the accepted start and applies the divergence rules to the
//   stimulus of each cycle.
module tb_sodor5_lockstep_monitor;

  localparam int XLEN  = 32;
  localparam int WARM  = 6;
  localparam int WIN   = 16;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             v1, v2;
  logic [XLEN-1:0]  a1, a2, d1, d2, p1, p2;
  logic             armed, diverged, done, pass;
  logic [3:0]       div_cause;
  logic [CNT_W-1:0] div_cycle;
  logic [XLEN-1:0]  snap_addr1, snap_addr2;
  logic [1:0]       fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: run activity, cycles since start, expected result record.
  bit               m_active;
  int               m_t;
  logic             e_div;
  logic [3:0]       e_cause;
  logic [CNT_W-1:0] e_cyc;
  logic [XLEN-1:0]  e_s1, e_s2;
  logic             e_done;

  sodor5_lockstep_monitor #(
    .XLEN(XLEN), .WARMUP_CYCLES(WARM), .CHECK_WINDOW(WIN), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .lb_valid1(v1), .lb_valid2(v2),
    .lb_addr1(a1), .lb_addr2(a2),
    .lb_data1(d1), .lb_data2(d2),
    .mem_pc1(p1), .mem_pc2(p2),
    .armed(armed), .diverged(diverged), .div_cause(div_cause),
    .div_cycle(div_cycle), .snap_addr1(snap_addr1), .snap_addr2(snap_addr2),
    .done(done), .pass(pass), .fsm_state(fsm_state)
  );

  // Clock: 10 time-unit period.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_cause();
    logic [3:0] c;
    c[0] = (v1 != v2);
    c[1] = v1 && v2 && (a1 != a2);
`ifdef LB_DATA_CHECK_EN
    c[2] = v1 && v2 && (d1 != d2);
`else
    c[2] = 1'b0;
`endif
    c[3] = (p1 != p2);
    return c;
  endfunction

  task automatic model_clear();
    e_div   = 1'b0;
    e_cause = 4'b0;
    e_cyc   = '0;
    e_s1    = '0;
    e_s2    = '0;
    e_done  = 1'b0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, ".diverged"}, diverged, e_div);
    chk({pfx, ".div_cause"}, div_cause, e_cause);
    chk({pfx, ".div_cycle"}, div_cycle, e_cyc);
    chk({pfx, ".snap_addr1"}, snap_addr1, e_s1);
    chk({pfx, ".snap_addr2"}, snap_addr2, e_s2);
    chk({pfx, ".done"}, done, e_done);
    chk({pfx, ".pass"}, pass, e_done && !e_div);
  endtask

  task automatic set_clean();
    v1 = 1'($urandom_range(0, 1));
    v2 = v1;
    a1 = $urandom; a2 = a1;
    d1 = $urandom; d2 = d1;
    p1 = $urandom; p2 = p1;
  endtask

  // One clock cycle: check armed, advance the model, clock, check results.
  task automatic step(input logic st);
    logic [3:0] c;
    int idx;
    start = st;
    #1;
    chk("armed", armed, m_active && (m_t > WARM));
    c = ref_cause();
    if (m_active && m_t > WARM) begin
      idx = m_t - WARM - 1;
      if (c != 4'b0) begin
        e_div    = 1'b1;
        e_cause  = c;
        e_cyc    = CNT_W'(idx);
        e_s1     = a1;
        e_s2     = a2;
        e_done   = 1'b1;
        m_active = 1'b0;
      end else if (idx == WIN - 1) begin
        e_done   = 1'b1;
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end else if (m_active) begin
      m_t++;
    end else if (st) begin
      model_clear();
      m_active = 1'b1;
      m_t      = 1;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    check_outputs("cyc");
  endtask

  task automatic clean_steps(input int n);
    for (int i = 0; i < n; i++) begin
      set_clean();
      step(1'b0);
    end
  endtask

  // Start a run and walk through the warm-up; the next step is armed cycle 0.
  task automatic start_and_warm();
    set_clean();
    step(1'b1);
    clean_steps(WARM);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_active = 1'b0;
    m_t      = 0;
    model_clear();
    check_outputs("rst_async");
    chk("rst_async.armed", armed, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("rst_edge");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_active = 1'b0;
    m_t = 0;
    model_clear();
    set_clean();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    chk("reset.armed", armed, 1'b0);
    reset = 1'b0;

    // Clean run: done/pass appear exactly 23 cycles after the start cycle.
    start_and_warm();
    clean_steps(WIN - 1);
    chk("clean.done_early", done, 1'b0);
    clean_steps(1);
    chk("clean.done", done, 1'b1);
    chk("clean.pass", pass, 1'b1);
    clean_steps(3);

    // Valid mismatch in armed cycle 3.
    start_and_warm();
    clean_steps(3);
    set_clean();
    v1 = 1'b1; v2 = 1'b0;
    step(1'b0);
    chk("vxor.diverged", diverged, 1'b1);
    chk("vxor.cause", div_cause, 4'b0001);
    chk("vxor.cycle", div_cycle, 3);
    chk("vxor.pass", pass, 1'b0);
    chk("vxor.done", done, 1'b1);
    clean_steps(4);

    // Address mismatch in armed cycle 0; start accepted from DONE clears flags.
    start_and_warm();
    chk("restart.diverged", diverged, 1'b0);
    set_clean();
    v1 = 1'b1; v2 = 1'b1;
    a1 = 32'h64; a2 = 32'h68;
    step(1'b0);
    chk("addr.cause", div_cause, 4'b0010);
    chk("addr.snap1", snap_addr1, 32'h64);
    chk("addr.snap2", snap_addr2, 32'h68);
    chk("addr.cycle", div_cycle, 0);

    // Data-only mismatch in armed cycle 2, then finish the window.
    start_and_warm();
    clean_steps(2);
    set_clean();
    v1 = 1'b1; v2 = 1'b1;
    d2 = ~d1;
    step(1'b0);
`ifdef LB_DATA_CHECK_EN
    chk("data.cause", div_cause, 4'b0100);
`else
    clean_steps(WIN - 3);
    chk("data.pass", pass, 1'b1);
`endif
    clean_steps(2);

    // Mismatches during warm-up only are ignored; a start while armed is dropped.
    set_clean();
    step(1'b1);
    for (int i = 0; i < WARM; i++) begin
      set_clean();
      p2 = ~p1;
      v2 = ~v1;
      step(1'b0);
    end
    clean_steps(2);
    set_clean();
    step(1'b1);
    clean_steps(WIN - 3);
    chk("warm.pass", pass, 1'b1);

    // Mismatch in the final window cycle plus an invalid-gated address diff.
    start_and_warm();
    for (int i = 0; i < WIN - 1; i++) begin
      set_clean();
      v1 = 1'b0; v2 = 1'b0;
      a2 = ~a1;
      step(1'b0);
    end
    set_clean();
    p2 = p1 + 32'd4;
    v1 = 1'b1; v2 = 1'b0;
    step(1'b0);
    chk("last.cause", div_cause, 4'b1001);
    chk("last.cycle", div_cycle, WIN - 1);
    chk("last.pass", pass, 1'b0);

    // Reset while armed clears everything.
    start_and_warm();
    clean_steps(4);
    do_reset();
    clean_steps(2);

    // Randomized runs with occasional start pulses and injected divergence.
    for (int n = 0; n < 600; n++) begin
      set_clean();
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 4))
          0: v2 = ~v1;
          1: begin v1 = 1'b1; v2 = 1'b1; a2 = a1 ^ (32'h1 << $urandom_range(0, 31)); end
          2: begin v1 = 1'b1; v2 = 1'b1; d2 = d1 ^ (32'h1 << $urandom_range(0, 31)); end
          3: p2 = p1 ^ (32'h1 << $urandom_range(0, 31));
          default: begin v1 = 1'b0; v2 = 1'b0; a2 = ~a1; d2 = ~d1; end
        endcase
      end
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 5) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
